// File: rtl/kd_tree_pkg.sv
// Shared definitions for the kd_tree root controller and the node array:
// command codes, bus widths, controller state encoding and error codes.
package kd_tree_pkg;

  localparam int KD_CMD_W  = 5;
  localparam int KD_DATA_W = 24;
  localparam int KD_CNT_W  = 10;

  localparam logic [4:0] CMD_NOP                     = 5'h00;
  localparam logic [4:0] CMD_CENTER_FILL             = 5'h01;
  localparam logic [4:0] CMD_CONFIGURE_SORT_AXIS     = 5'h02;
  localparam logic [4:0] CMD_CENTER_FILL_DONE        = 5'h05;
  localparam logic [4:0] CMD_CONFIGURE_SORT_AXIS_DONE = 5'h07;
  localparam logic [4:0] CMD_START_SORTING           = 5'h09;
  localparam logic [4:0] CMD_VALID_SORT              = 5'h0f;
  localparam logic [4:0] CMD_RST_DONE                = 5'h1e;
  localparam logic [4:0] CMD_RST                     = 5'h1f;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RST  = 3'd1,
    ST_FILL = 3'd2,
    ST_AXIS = 3'd3,
    ST_SORT = 3'd4,
    ST_WAIT = 3'd5,
    ST_DONE = 3'd6
  } ctrl_state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CFG     = 2'd1;
  localparam logic [1:0] ERR_COUNT   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/kd_ctrl_watchdog.sv
// Stall watchdog: reloads to all-ones on load, counts down while enabled,
// and flags expiry when an enabled cycle finds the count exhausted.
module kd_ctrl_watchdog #(
  parameter int TO_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  logic [TO_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '1;
    end else if (load) begin
      cnt_q <= '1;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = en && (cnt_q == '0);

endmodule

// File: rtl/kd_tree_root_ctrl.sv
// Root sequencer for the kd_tree: reset tree, fill centers, set axis, sort, await valid_sort.
// Optional watchdog on stalled phases is built in when KD_CTRL_TIMEOUT_EN is defined.
//
//  state | meaning
//  IDLE  | waiting for start, outputs quiet
//  RST   | driving rst until root answers rst_done
//  FILL  | forwarding host centers until center_fill_done
//  AXIS  | driving configure_sort_axis until its done
//  SORT  | single start_sorting cycle
//  WAIT  | waiting for valid_sort, captures root center
//  DONE  | one-cycle done pulse
module kd_tree_root_ctrl
  import kd_tree_pkg::*;
#(
  parameter int CMD_W  = KD_CMD_W,
  parameter int DATA_W = KD_DATA_W,
  parameter int CNT_W  = KD_CNT_W,
  parameter int TO_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        cfg_axis,
  input  logic [CNT_W-1:0]  cfg_num_centers,
  input  logic [DATA_W-1:0] center_data,
  input  logic              center_valid,
  output logic              center_ready,
  output logic [CMD_W-1:0]  cmd_to_root,
  output logic [DATA_W-1:0] data_to_root,
  input  logic [CMD_W-1:0]  cmd_from_root,
  input  logic [DATA_W-1:0] data_from_root,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [DATA_W-1:0] root_center
);

  ctrl_state_e       state_q, state_nxt;
  logic [CNT_W-1:0]  count_q, count_nxt;
  logic [CNT_W-1:0]  num_q, num_nxt;
  logic [1:0]        axis_q, axis_nxt;
  logic [CMD_W-1:0]  cmd_nxt;
  logic [DATA_W-1:0] data_nxt, rc_nxt;
  logic              ready_nxt, done_nxt, error_nxt, fill_beat;
  logic [1:0]        code_nxt;
  logic              cfg_ok, wd_expired;

  assign cfg_ok = (cfg_axis != 2'b11) && (cfg_num_centers != '0);

`ifdef KD_CTRL_TIMEOUT_EN
  logic wd_load, wd_en;

  assign wd_load = (state_nxt != state_q) || abort;
  assign wd_en   = (state_q == ST_RST) || (state_q == ST_AXIS) || (state_q == ST_WAIT) ||
                   ((state_q == ST_FILL) && center_valid && !center_ready);

  kd_ctrl_watchdog #(.TO_W(TO_W)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .load    (wd_load),
    .en      (wd_en),
    .expired (wd_expired)
  );
`else
  // watchdog absent: never expires, FSM waits on the root indefinitely
  assign wd_expired = 1'b0 && (TO_W > 0);
`endif

  always_comb begin
    state_nxt = state_q;
    count_nxt = count_q;
    num_nxt   = num_q;
    axis_nxt  = axis_q;
    data_nxt  = data_to_root;
    rc_nxt    = root_center;
    error_nxt = error;
    code_nxt  = err_code;
    fill_beat = 1'b0;

    if ((state_q != ST_IDLE) && abort) begin
      state_nxt = ST_RST;
      count_nxt = '0;
    end else if (wd_expired) begin
      state_nxt = ST_IDLE;
      error_nxt = 1'b1;
      code_nxt  = ERR_TIMEOUT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            if (cfg_ok) begin
              state_nxt = ST_RST;
              num_nxt   = cfg_num_centers;
              axis_nxt  = cfg_axis;
              count_nxt = '0;
              error_nxt = 1'b0;
              code_nxt  = ERR_NONE;
            end else begin
              error_nxt = 1'b1;
              code_nxt  = ERR_CFG;
            end
          end
        end
        ST_RST:  if (cmd_from_root == CMD_RST_DONE) state_nxt = ST_FILL;
        ST_FILL: begin
          if (cmd_from_root == CMD_CENTER_FILL_DONE) begin
            if (count_q == num_q) begin
              state_nxt = ST_AXIS;
            end else begin
              state_nxt = ST_IDLE;
              error_nxt = 1'b1;
              code_nxt  = ERR_COUNT;
            end
          end else if (center_valid && center_ready) begin
            fill_beat = 1'b1;
            data_nxt  = center_data;
            count_nxt = count_q + 1'b1;
          end
        end
        ST_AXIS: if (cmd_from_root == CMD_CONFIGURE_SORT_AXIS_DONE) state_nxt = ST_SORT;
        ST_SORT: state_nxt = ST_WAIT;
        ST_WAIT: begin
          if (cmd_from_root == CMD_VALID_SORT) begin
            rc_nxt    = data_from_root;
            state_nxt = ST_DONE;
          end
        end
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end

    // outputs are registered, so they are decoded from the state being entered
    cmd_nxt = CMD_NOP;
    case (state_nxt)
      ST_RST:  cmd_nxt = CMD_RST;
      ST_FILL: if (fill_beat) cmd_nxt = CMD_CENTER_FILL;
      ST_AXIS: begin
        cmd_nxt  = CMD_CONFIGURE_SORT_AXIS;
        data_nxt = {{(DATA_W-2){1'b0}}, axis_nxt};
      end
      ST_SORT: begin
        cmd_nxt  = CMD_START_SORTING;
        data_nxt = {{(DATA_W-2){1'b0}}, axis_nxt};
      end
      default: ;
    endcase
    ready_nxt = (state_nxt == ST_FILL) && (count_nxt != num_nxt);
    done_nxt  = (state_nxt == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      num_q        <= '0;
      axis_q       <= '0;
      cmd_to_root  <= CMD_NOP;
      data_to_root <= '0;
      center_ready <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= ERR_NONE;
      root_center  <= '0;
    end else begin
      state_q      <= state_nxt;
      count_q      <= count_nxt;
      num_q        <= num_nxt;
      axis_q       <= axis_nxt;
      cmd_to_root  <= cmd_nxt;
      data_to_root <= data_nxt;
      center_ready <= ready_nxt;
      busy         <= (state_nxt != ST_IDLE);
      done         <= done_nxt;
      error        <= error_nxt;
      err_code     <= code_nxt;
      root_center  <= rc_nxt;
    end
  end

endmodule

// File: tb/tb_kd_tree_root_ctrl.sv
// Bench for kd_tree_root_ctrl: behavioural root node and host stream, table-driven
// and randomized builds judged by an outcome model, plus abort/reset sequences.
module tb_kd_tree_root_ctrl;
  import kd_tree_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort;
  logic [1:0]  cfg_axis;
  logic [9:0]  cfg_num_centers;
  logic [23:0] center_data;
  logic        center_valid, center_ready;
  logic [4:0]  cmd_to_root, cmd_from_root;
  logic [23:0] data_to_root, data_from_root, root_center;
  logic        busy, done, error;
  logic [1:0]  err_code;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [23:0] exp_rc;
  logic [1:0]  last_code;

  typedef struct {
    logic [1:0]  axis;
    int          n;
    int          lim;
    int          fdelay;
    logic [31:0] vpat;
    logic [23:0] rc;
    bit          abort_wait;
    logic [1:0]  exp_code;
    bit          exp_done;
  } vec_t;

  always #5 clk = ~clk;

  kd_tree_root_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .cfg_axis        (cfg_axis),
    .cfg_num_centers (cfg_num_centers),
    .center_data     (center_data),
    .center_valid    (center_valid),
    .center_ready    (center_ready),
    .cmd_to_root     (cmd_to_root),
    .data_to_root    (data_to_root),
    .cmd_from_root   (cmd_from_root),
    .data_from_root  (data_from_root),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .err_code        (err_code),
    .root_center     (root_center)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Outcome of one build from the rules: bad cfg, early fill_done, or success.
  function automatic logic [1:0] model_code(logic [1:0] axis, int n, int lim);
    if (axis == 2'd3 || n == 0) return ERR_CFG;
    if (lim < n) return ERR_COUNT;
    return ERR_NONE;
  endfunction

  task automatic run_txn(input vec_t v);
    logic [23:0] hdata[$];
    logic [23:0] got[$];
    int idx = 0, base = 0, cyc = 0, rst_run = 0, sort_wait = 0, fd_cnt = 0;
    int sort_cnt = 0, done_cnt = 0, axis_bad = 0, data_bad = 0, over = 0, exp_k;
    bit fd_sent = 0, aborted = 0, chk_rst = 0, fin = 0, legal;
    for (int i = 0; i < 2 * v.n + 4; i++) hdata.push_back(24'($urandom));
    legal = (v.axis != 2'd3) && (v.n != 0);
    cfg_axis = v.axis;
    cfg_num_centers = 10'(v.n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_axis = 2'($urandom);
    cfg_num_centers = 10'($urandom_range(0, 9));
    check("start_busy", busy, legal);
    check("start_error", error, !legal);
    check("start_cmd", cmd_to_root, legal ? CMD_RST : CMD_NOP);
    while (!fin) begin
      center_data = (idx < hdata.size()) ? hdata[idx] : 24'h0;
      if (chk_rst) begin
        check("abort_to_rst", cmd_to_root, CMD_RST);
        check("abort_busy", busy, 1);
        chk_rst = 0;
      end
      if (done) done_cnt++;
      if (center_ready && (idx - base) >= v.n) over++;
      if (cmd_to_root == CMD_CENTER_FILL) got.push_back(data_to_root);
      if (cmd_to_root == CMD_CONFIGURE_SORT_AXIS || cmd_to_root == CMD_START_SORTING)
        if (data_to_root != {22'b0, v.axis}) axis_bad++;
      if (cmd_to_root == CMD_START_SORTING) sort_cnt++;
      if (!busy) begin
        fin = 1;
      end else begin
        cmd_from_root  = CMD_NOP;
        data_from_root = 24'($urandom);
        abort = 1'b0;
        start = (cyc == 5);
        if (cmd_to_root == CMD_RST) begin
          rst_run++;
          if (rst_run == 2) begin cmd_from_root = CMD_RST_DONE; rst_run = 0; end
        end else rst_run = 0;
        if (!fd_sent && got.size() >= v.lim) begin
          if (fd_cnt == v.fdelay) begin cmd_from_root = CMD_CENTER_FILL_DONE; fd_sent = 1; end
          else fd_cnt++;
        end
        if (cmd_to_root == CMD_CONFIGURE_SORT_AXIS) cmd_from_root = CMD_CONFIGURE_SORT_AXIS_DONE;
        if (cmd_to_root == CMD_START_SORTING) sort_wait = 3;
        else if (sort_wait > 0) begin
          sort_wait--;
          if (v.abort_wait && !aborted) begin
            abort = 1'b1; aborted = 1; chk_rst = 1; sort_wait = 0;
            got.delete(); base = idx; fd_sent = 0; fd_cnt = 0;
          end else if (sort_wait == 0) begin
            cmd_from_root  = CMD_VALID_SORT;
            data_from_root = v.rc;
          end
        end
        center_valid = v.vpat[cyc % 32] && (idx < hdata.size());
        if (center_valid && center_ready) idx++;
        @(posedge clk); #1;
        cyc++;
        if (cyc > 1000) begin
          n_cmp++; n_bad++;
          $display("FAIL txn_timeout: still busy after %0d cycles, required idle", cyc);
          fin = 1;
        end
      end
    end
    start = 1'b0; abort = 1'b0; center_valid = 1'b0; cmd_from_root = CMD_NOP;
    exp_k = !legal ? 0 : (v.lim < v.n ? v.lim : v.n);
    for (int i = 0; i < got.size() && i < exp_k; i++)
      if (got[i] != hdata[base + i]) data_bad++;
    if (v.exp_done) exp_rc = v.rc;
    check("fill_count", got.size(), exp_k);
    check("fill_data", data_bad, 0);
    check("axis_data", axis_bad, 0);
    check("sort_cmds", sort_cnt, v.exp_done ? (v.abort_wait ? 2 : 1) : 0);
    check("done_pulses", done_cnt, v.exp_done ? 1 : 0);
    check("error", error, v.exp_code != ERR_NONE);
    check("err_code", err_code, v.exp_code);
    check("root_center", root_center, exp_rc);
    check("ready_after_full", over, 0);
    last_code = v.exp_code;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    vec_t tbl[8];
    vec_t rv;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_axis = 2'd0; cfg_num_centers = '0;
    center_data = '0; center_valid = 1'b0; cmd_from_root = CMD_NOP; data_from_root = '0;
    exp_rc = '0; last_code = ERR_NONE;

    tbl[0] = '{2'd1, 3, 3, 0, 32'hffff_ffff, 24'h102030, 0, ERR_NONE,  1};
    tbl[1] = '{2'd0, 3, 3, 0, 32'h5555_5555, 24'habcdef, 0, ERR_NONE,  1};
    tbl[2] = '{2'd2, 3, 2, 0, 32'hffff_ffff, 24'h111111, 0, ERR_COUNT, 0};
    tbl[3] = '{2'd3, 3, 3, 0, 32'hffff_ffff, 24'h222222, 0, ERR_CFG,   0};
    tbl[4] = '{2'd0, 0, 0, 0, 32'hffff_ffff, 24'h333333, 0, ERR_CFG,   0};
    tbl[5] = '{2'd1, 4, 4, 3, 32'hffff_ffff, 24'h445566, 0, ERR_NONE,  1};
    tbl[6] = '{2'd2, 2, 2, 0, 32'h3333_3333, 24'h778899, 1, ERR_NONE,  1};
    tbl[7] = '{2'd0, 1, 1, 0, 32'hffff_ffff, 24'h0a0b0c, 0, ERR_NONE,  1};

    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd", cmd_to_root, CMD_NOP);
    check("rst_data", data_to_root, 0);
    check("rst_ready", center_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_err_code", err_code, 0);
    check("rst_root_center", root_center, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) run_txn(tbl[i]);

    // abort together with an illegal start in IDLE must be a no-op
    cfg_axis = 2'd3; cfg_num_centers = 10'd2; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("idle_abort_busy", busy, 0);
    check("idle_abort_cmd", cmd_to_root, CMD_NOP);
    check("idle_abort_code", err_code, last_code);

    for (int t = 0; t < 20; t++) begin
      rv.axis = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      rv.n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
      rv.lim = (rv.n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, rv.n) : rv.n;
      rv.fdelay = (rv.lim == rv.n) ? $urandom_range(0, 3) : 0;
      rv.vpat = $urandom | 32'h1;
      rv.rc = 24'($urandom);
      rv.exp_code = model_code(rv.axis, rv.n, rv.lim);
      rv.exp_done = (rv.exp_code == ERR_NONE);
      rv.abort_wait = rv.exp_done && ($urandom_range(0, 4) == 0);
      run_txn(rv);
    end

    // asynchronous reset in the middle of a build
    cfg_axis = 2'd1; cfg_num_centers = 10'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_cmd", cmd_to_root, CMD_NOP);
    check("async_rst_root_center", root_center, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
